byte_serializer: RTL and testbench

BYTE_SERIALIZER -- requirements
Module: byte_serializer

---
 rtl/byte_serializer.sv | 191 +++++++++++++++++++
 tb/tb_byte_serializer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serializer.sv
// byte_serializer
// Buffers 32-bit words (with a byte count) in a small FIFO and emits them one
// byte per clock, LSB first, on a registered dout / ren_n / dout_last strobe.
// A downstream stall pauses emission without losing or repeating bytes.
module byte_serializer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_len,
  input  logic        stall,
  output logic [7:0]  dout,
  output logic        ren_n,
  output logic        dout_last,
  output logic        busy
);

  // Pointer index width; the extra MSB on each pointer is the wrap bit.
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Byte lane picker for the working word.
  function automatic logic [7:0] select_byte(input logic [31:0] word,
                                             input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // FIFO storage and pointers
  logic [31:0] word_mem_q [DEPTH];
  logic [1:0]  len_mem_q  [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_idx_s, rd_idx_s;
  logic        fifo_empty_s;
  logic        fifo_full_s;
  logic        push_s;
  logic        pop_s;
  logic [31:0] head_word_s;
  logic [1:0]  head_len_s;

  // Serializer state
  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  len_q, len_d;
  logic [1:0]  idx_q, idx_d;
  logic        last_byte_s;

  // Registered output strobe
  logic [7:0]  dout_q, dout_d;
  logic        ren_n_q, ren_n_d;
  logic        last_q, last_d;

  assign wr_idx_s     = wr_ptr_q[AW-1:0];
  assign rd_idx_s     = rd_ptr_q[AW-1:0];
  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_word_s  = word_mem_q[rd_idx_s];
  assign head_len_s   = len_mem_q[rd_idx_s];

  // Acceptance is refused while reset is held so nothing sneaks in.
  assign in_ready = rst_n & ~fifo_full_s;
  assign push_s   = in_valid & in_ready;

  assign last_byte_s = (idx_q == len_q);

  assign dout      = dout_q;
  assign ren_n     = ren_n_q;
  assign dout_last = last_q;
  assign busy      = ~fifo_empty_s | (state_q == ST_SEND) | ~ren_n_q;

  // FIFO storage: written only on an accepted push, contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      word_mem_q[wr_idx_s] <= in_data;
      len_mem_q[wr_idx_s]  <= in_len;
    end
  end

  // FIFO pointer advance; push and pop are independent so occupancy holds on both.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Serializer next state: pop into the working word, then walk the byte index.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    len_d   = len_q;
    idx_d   = idx_q;
    pop_s   = 1'b0;
    dout_d  = 8'h00;
    ren_n_d = 1'b1;
    last_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Loading the working word is not gated by stall.
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          word_d  = head_word_s;
          len_d   = head_len_s;
          idx_d   = 2'd0;
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!stall) begin
          dout_d  = select_byte(word_q, idx_q);
          ren_n_d = 1'b0;
          last_d  = last_byte_s;
          if (last_byte_s) begin
            // Chain straight into the next word so there is no bubble.
            if (!fifo_empty_s) begin
              pop_s   = 1'b1;
              word_d  = head_word_s;
              len_d   = head_len_s;
              idx_d   = 2'd0;
              state_d = ST_SEND;
            end else begin
              idx_d   = 2'd0;
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          // Stalled: hold word and index, strobe stays inactive.
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  // State, pointer and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      word_q   <= 32'h0000_0000;
      len_q    <= 2'd0;
      idx_q    <= 2'd0;
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
      dout_q   <= 8'h00;
      ren_n_q  <= 1'b1;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
      ren_n_q  <= ren_n_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench for byte_serializer: directed scenarios plus random
// traffic, with a byte-level scoreboard checked by an independent monitor.
module tb_byte_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_len;
  logic        stall;
  logic [7:0]  dout;
  logic        ren_n;
  logic        dout_last;
  logic        busy;

  int vec_cnt;
  int err_cnt;
  int acc_cnt;
  int last_cnt;
  bit mon_en;

  // Expected byte stream: {last_flag, byte}
  logic [8:0] exp_q [$];

  byte_serializer #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .stall     (stall),
    .dout      (dout),
    .ren_n     (ren_n),
    .dout_last (dout_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs seen mid-cycle reflect the previous edge; then the
  // inputs present now decide what the upcoming edge accepts or flushes.
  always @(negedge clk) begin
    logic [8:0] e;
    if (mon_en) begin
      check("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
      if (!ren_n) begin
        if (dout_last) last_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_strobe", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("dout", {24'd0, dout}, {24'd0, e[7:0]});
          check("dout_last", {31'd0, dout_last}, {31'd0, e[8]});
        end
      end else begin
        check("idle_dout", {24'd0, dout}, 32'd0);
        check("idle_last", {31'd0, dout_last}, 32'd0);
      end
      if (!rst_n) begin
        exp_q.delete();
      end else if (in_valid && in_ready) begin
        acc_cnt++;
        for (int i = 0; i <= int'(in_len); i++) begin
          exp_q.push_back({(i == int'(in_len)), in_data[8*i +: 8]});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic [1:0] l);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_len   = l;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("push_ready_timeout", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_strobe(input logic [7:0] b, input logic last);
    int n;
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < 20) begin
      step();
      n++;
      if (!ren_n && dout == b) found = 1'b1;
    end
    check("wait_strobe_found", {31'd0, found}, 32'd1);
    check("wait_strobe_last", {31'd0, dout_last}, {31'd0, last});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    check("drain_timeout", {31'd0, busy}, 32'd0);
    check("drain_queue_empty", exp_q.size(), 32'd0);
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, last0;
    vec_cnt = 0; err_cnt = 0; acc_cnt = 0; last_cnt = 0; mon_en = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_len = 2'd0; stall = 1'b0;

    // Reset state
    step();
    step();
    mon_en = 1'b1;
    check("rst_ren_n", {31'd0, ren_n}, 32'd1);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_last", {31'd0, dout_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single 4-byte word, exact latency
    push_word(32'h44332211, 2'd3);            // returns just after E0
    check("lat_e0_ren_n", {31'd0, ren_n}, 32'd1);
    step();                                   // E1: pop
    check("lat_e1_ren_n", {31'd0, ren_n}, 32'd1);
    check("lat_e1_busy", {31'd0, busy}, 32'd1);
    step();                                   // E2: byte 0
    check("lat_b0_ren_n", {31'd0, ren_n}, 32'd0);
    check("lat_b0", {24'd0, dout}, 32'h11);
    check("lat_b0_last", {31'd0, dout_last}, 32'd0);
    step();
    check("lat_b1", {23'd0, ren_n, dout}, 32'h022);
    step();
    check("lat_b2", {23'd0, ren_n, dout}, 32'h033);
    step();
    check("lat_b3", {22'd0, ren_n, dout_last, dout}, 32'h144);
    step();
    check("lat_end_ren_n", {31'd0, ren_n}, 32'd1);
    check("lat_end_busy", {31'd0, busy}, 32'd0);

    // Back-to-back words without a bubble
    push_word(32'h000000AA, 2'd0);
    push_word(32'h0000CCBB, 2'd1);
    wait_strobe(8'hAA, 1'b1);
    step();
    check("b2b_bb", {22'd0, ren_n, dout_last, dout}, 32'h0BB);
    step();
    check("b2b_cc", {22'd0, ren_n, dout_last, dout}, 32'h1CC);
    drain();

    // Stall held: FIFO fills, 4th push refused, nothing emitted
    stall = 1'b1;
    push_word(32'hA3A2A1A0, 2'd3);
    push_word(32'hB3B2B1B0, 2'd2);
    push_word(32'hC3C2C1C0, 2'd1);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    in_len   = 2'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_ren_n", {31'd0, ren_n}, 32'd1);
      check("full_refuse", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    stall = 1'b0;
    drain();

    // Two-cycle stall after byte 0x22
    push_word(32'h44332211, 2'd3);
    wait_strobe(8'h22, 1'b0);
    stall = 1'b1;
    step();
    check("stall1", {23'd0, ren_n, dout}, 32'h100);
    step();
    check("stall2", {23'd0, ren_n, dout}, 32'h100);
    stall = 1'b0;
    step();
    check("stall_b2", {23'd0, ren_n, dout}, 32'h033);
    step();
    check("stall_b3", {22'd0, ren_n, dout_last, dout}, 32'h144);
    drain();

    // Reset mid-word with a second word queued
    push_word(32'h44332211, 2'd3);
    push_word(32'h88776655, 2'd3);
    wait_strobe(8'h11, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("rst_mid", {22'd0, busy, ren_n, dout}, 32'h100);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_mid_quiet", {31'd0, ren_n}, 32'd1);
    end

    // Random traffic
    acc0  = acc_cnt;
    last0 = last_cnt;
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = $urandom;
      in_len   = 2'($urandom_range(0, 3));
      stall    = ($urandom_range(0, 3) == 0);
      step();
    end
    in_valid = 1'b0;
    stall = 1'b0;
    drain();
    check("rand_last_count", last_cnt - last0, acc_cnt - acc0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
